// File: rtl/rob_commit_pkg.sv
// Shared sizing for the reorder buffer and the register file that consumes it.
package rob_commit_pkg;

  localparam int ROB_WIDTH_BIT = 3;
  localparam int ROB_WIDTH     = 2 ** ROB_WIDTH_BIT;
  localparam int REG_ID_BIT    = 5;
  localparam int REG_ID_WIDTH  = 2 ** REG_ID_BIT;
  localparam int DATA_W        = 32;

  typedef logic [ROB_WIDTH_BIT-1:0] rob_tag_t;
  typedef logic [REG_ID_BIT-1:0]    reg_id_t;
  typedef logic [DATA_W-1:0]        word_t;
  typedef logic [ROB_WIDTH_BIT:0]   rob_cnt_t;

  localparam rob_cnt_t ROB_FULL_COUNT = rob_cnt_t'(ROB_WIDTH);
  localparam rob_cnt_t ROB_CNT_ONE    = rob_cnt_t'(1);
  localparam rob_tag_t ROB_TAG_ONE    = rob_tag_t'(1);

endpackage

// File: rtl/rob_commit_if.sv
// Issue / CDB / operand lookup / commit bundle between the core and the ROB.
interface rob_commit_if;
  import rob_commit_pkg::*;

  logic     issue_valid;
  reg_id_t  issue_rd;
  rob_tag_t issue_tag;
  logic     full;

  logic     cdb_valid;
  rob_tag_t cdb_tag;
  word_t    cdb_value;

  rob_tag_t q1_tag, q2_tag;
  logic     q1_ready, q2_ready;
  word_t    q1_value, q2_value;

  logic     commit_valid;
  logic     commit_we;
  reg_id_t  commit_rd;
  word_t    commit_value;
  rob_tag_t commit_tag;
  rob_cnt_t count;

  modport slave (
    input  issue_valid, issue_rd, cdb_valid, cdb_tag, cdb_value, q1_tag, q2_tag,
    output issue_tag, full, q1_ready, q2_ready, q1_value, q2_value,
           commit_valid, commit_we, commit_rd, commit_value, commit_tag, count
  );

  modport master (
    output issue_valid, issue_rd, cdb_valid, cdb_tag, cdb_value, q1_tag, q2_tag,
    input  issue_tag, full, q1_ready, q2_ready, q1_value, q2_value,
           commit_valid, commit_we, commit_rd, commit_value, commit_tag, count
  );
endinterface

// File: rtl/rob_commit_lookup.sv
// Combinational operand read port; ROB_CDB_BYPASS_EN adds same-cycle CDB forwarding.
module rob_lookup
  import rob_commit_pkg::*;
(
  input  logic [ROB_WIDTH-1:0]         busy,
  input  logic [ROB_WIDTH-1:0]         ready,
  input  logic [ROB_WIDTH-1:0][DATA_W-1:0] value,
`ifdef ROB_CDB_BYPASS_EN
  input  logic                         cdb_valid,
  input  rob_tag_t                     cdb_tag,
  input  word_t                        cdb_value,
`endif
  input  rob_tag_t                     tag,
  output logic                         q_ready,
  output word_t                        q_value
);

  logic stored;
  assign stored = busy[tag] && ready[tag];

`ifdef ROB_CDB_BYPASS_EN
  logic hit;
  assign hit     = cdb_valid && (cdb_tag == tag) && busy[tag];
  assign q_ready = stored || hit;
  assign q_value = stored ? value[tag] : (hit ? cdb_value : '0);
`else
  assign q_ready = stored;
  assign q_value = stored ? value[tag] : '0;
`endif

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate, CDB capture, in-order retire to the regfile.
// Optional same-cycle operand forwarding under ROB_CDB_BYPASS_EN.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  rob_commit_if.slave bus
);

  logic [ROB_WIDTH-1:0]             busy, ready;
  logic [ROB_WIDTH-1:0][REG_ID_BIT-1:0] rd_q;
  logic [ROB_WIDTH-1:0][DATA_W-1:0] value_q;
  rob_tag_t head, tail;
  rob_cnt_t cnt;

  logic     cv_q;
  reg_id_t  crd_q;
  word_t    cval_q;
  rob_tag_t ctag_q;

  logic full_w, issue_ok, commit_ok;
  assign full_w    = (cnt == ROB_FULL_COUNT);
  assign issue_ok  = bus.issue_valid && !full_w;
  assign commit_ok = busy[head] && ready[head];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy    <= '0;
      ready   <= '0;
      rd_q    <= '0;
      value_q <= '0;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      cv_q    <= 1'b0;
      crd_q   <= '0;
      cval_q  <= '0;
      ctag_q  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        cnt   <= '0;
        cv_q  <= 1'b0;
      end else begin
        // The entry being allocated is never busy, so a CDB write cannot collide with issue.
        if (bus.cdb_valid && busy[bus.cdb_tag]) begin
          ready[bus.cdb_tag]   <= 1'b1;
          value_q[bus.cdb_tag] <= bus.cdb_value;
        end
        if (issue_ok) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          rd_q[tail]  <= bus.issue_rd;
          tail        <= tail + ROB_TAG_ONE;
        end
        cv_q <= commit_ok;
        if (commit_ok) begin
          busy[head] <= 1'b0;
          head       <= head + ROB_TAG_ONE;
          crd_q      <= rd_q[head];
          cval_q     <= value_q[head];
          ctag_q     <= head;
        end
        case ({issue_ok, commit_ok})
          2'b10:   cnt <= cnt + ROB_CNT_ONE;
          2'b01:   cnt <= cnt - ROB_CNT_ONE;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Pause masks the pulse without consuming it; it reappears once rdy_in returns.
  assign bus.commit_valid = cv_q && rdy_in;
  assign bus.commit_we    = bus.commit_valid && (crd_q != '0);
  assign bus.commit_rd    = crd_q;
  assign bus.commit_value = cval_q;
  assign bus.commit_tag   = ctag_q;
  assign bus.issue_tag    = tail;
  assign bus.full         = full_w;
  assign bus.count        = cnt;

  rob_lookup u_q1 (
    .busy      (busy),
    .ready     (ready),
    .value     (value_q),
`ifdef ROB_CDB_BYPASS_EN
    .cdb_valid (bus.cdb_valid),
    .cdb_tag   (bus.cdb_tag),
    .cdb_value (bus.cdb_value),
`endif
    .tag       (bus.q1_tag),
    .q_ready   (bus.q1_ready),
    .q_value   (bus.q1_value)
  );

  rob_lookup u_q2 (
    .busy      (busy),
    .ready     (ready),
    .value     (value_q),
`ifdef ROB_CDB_BYPASS_EN
    .cdb_valid (bus.cdb_valid),
    .cdb_tag   (bus.cdb_tag),
    .cdb_value (bus.cdb_value),
`endif
    .tag       (bus.q2_tag),
    .q_ready   (bus.q2_ready),
    .q_value   (bus.q2_value)
  );

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit; expectations follow ROB_CDB_BYPASS_EN when defined.
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic flush_in = 1'b0;
  int   passed = 0;
  int   total  = 0;

  rob_commit_if bus ();

  rob_commit dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #2;
    rst_in = 1'b1;
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_value   = '0;
  endtask

  initial begin
    idle_inputs();
    bus.q1_tag = '0;
    bus.q2_tag = '0;
    #3;
    check("rst_count", 32'(bus.count), 0);
    check("rst_cv", 32'(bus.commit_valid), 0);
    check("rst_we", 32'(bus.commit_we), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_tag", 32'(bus.issue_tag), 0);
    check("rst_crd", 32'(bus.commit_rd), 0);
    check("rst_cval", bus.commit_value, 0);
    rst_in = 1'b1;
    step();

    // single issue / CDB / commit
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    #1 check("t1_issue_tag", 32'(bus.issue_tag), 0);
    step();
    bus.issue_valid = 1'b0;
    check("t1_count1", 32'(bus.count), 1);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd0; bus.cdb_value = 32'h1234;
    step();
    bus.cdb_valid = 1'b0;
    check("t1_no_early_cv", 32'(bus.commit_valid), 0);
    step();
    check("t1_cv", 32'(bus.commit_valid), 1);
    check("t1_rd", 32'(bus.commit_rd), 5);
    check("t1_val", bus.commit_value, 32'h1234);
    check("t1_ctag", 32'(bus.commit_tag), 0);
    check("t1_we", 32'(bus.commit_we), 1);
    check("t1_count0", 32'(bus.count), 0);
    step();
    check("t1_cv_pulse", 32'(bus.commit_valid), 0);

    // fill, overflow, out-of-order completion
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = reg_id_t'(i + 1);
      step();
    end
    check("t2_full", 32'(bus.full), 1);
    check("t2_count8", 32'(bus.count), 8);
    bus.issue_rd = 5'd9;
    step();
    bus.issue_valid = 1'b0;
    check("t2_reject_count", 32'(bus.count), 8);
    check("t2_reject_tail", 32'(bus.issue_tag), 0);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd3; bus.cdb_value = 32'h103;
    step();
    check("t2_cv_a", 32'(bus.commit_valid), 0);
    bus.cdb_tag = 3'd0; bus.cdb_value = 32'h100;
    step();
    check("t2_cv_b", 32'(bus.commit_valid), 0);
    bus.cdb_tag = 3'd1; bus.cdb_value = 32'h101;
    step();
    check("t2_c0_cv", 32'(bus.commit_valid), 1);
    check("t2_c0_tag", 32'(bus.commit_tag), 0);
    check("t2_c0_rd", 32'(bus.commit_rd), 1);
    check("t2_c0_val", bus.commit_value, 32'h100);
    bus.cdb_tag = 3'd2; bus.cdb_value = 32'h102;
    step();
    bus.cdb_valid = 1'b0;
    check("t2_c1_tag", 32'(bus.commit_tag), 1);
    step();
    check("t2_c2_tag", 32'(bus.commit_tag), 2);
    check("t2_c2_cv", 32'(bus.commit_valid), 1);
    step();
    check("t2_c3_tag", 32'(bus.commit_tag), 3);
    check("t2_c3_val", bus.commit_value, 32'h103);
    check("t2_c3_rd", 32'(bus.commit_rd), 4);
    step();
    check("t2_idle_cv", 32'(bus.commit_valid), 0);
    check("t2_count4", 32'(bus.count), 4);

    // drain 4..7, head wraps to 0, refill 5
    for (int t = 4; t < 8; t++) begin
      bus.cdb_valid = 1'b1; bus.cdb_tag = rob_tag_t'(t); bus.cdb_value = 32'h200 + 32'(t);
      step();
      if (t > 4) check("t3_drain_tag", 32'(bus.commit_tag), 32'(t - 1));
    end
    bus.cdb_valid = 1'b0;
    step();
    check("t3_drain7_tag", 32'(bus.commit_tag), 7);
    check("t3_drain7_val", bus.commit_value, 32'h207);
    check("t3_empty", 32'(bus.count), 0);
    for (int i = 0; i < 5; i++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = reg_id_t'(10 + i);
      #1 check("t3_refill_tag", 32'(bus.issue_tag), 32'(i));
      step();
    end
    bus.issue_valid = 1'b0;
    check("t3_count5", 32'(bus.count), 5);
    for (int t = 0; t < 5; t++) begin
      bus.cdb_valid = 1'b1; bus.cdb_tag = rob_tag_t'(t); bus.cdb_value = 32'h300 + 32'(t);
      step();
      if (t > 0) check("t3_refill_ctag", 32'(bus.commit_tag), 32'(t - 1));
    end
    bus.cdb_valid = 1'b0;
    step();
    check("t3_last_tag", 32'(bus.commit_tag), 4);
    check("t3_last_rd", 32'(bus.commit_rd), 14);
    check("t3_count0", 32'(bus.count), 0);

    // rd == 0 retires without regfile write
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    step();
    bus.issue_valid = 1'b0;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd5; bus.cdb_value = 32'hdead;
    step();
    bus.cdb_valid = 1'b0;
    step();
    check("t4_cv", 32'(bus.commit_valid), 1);
    check("t4_we", 32'(bus.commit_we), 0);
    check("t4_tag", 32'(bus.commit_tag), 5);
    check("t4_count", 32'(bus.count), 0);
    check("t4_tail", 32'(bus.issue_tag), 6);

    // flush discards simultaneous issue and CDB
    for (int i = 0; i < 3; i++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = reg_id_t'(i + 1);
      step();
    end
    check("t5_count3", 32'(bus.count), 3);
    flush_in = 1'b1;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd6; bus.cdb_value = 32'h55;
    step();
    flush_in = 1'b0;
    idle_inputs();
    check("t5_count0", 32'(bus.count), 0);
    check("t5_cv", 32'(bus.commit_valid), 0);
    check("t5_tag0", 32'(bus.issue_tag), 0);
    bus.q1_tag = 3'd6;
    step();
    check("t5_cv_next", 32'(bus.commit_valid), 0);
    check("t5_q1_cleared", 32'(bus.q1_ready), 0);

    // operand lookup, with and without same-cycle forwarding
    for (int i = 0; i < 3; i++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = reg_id_t'(20 + i);
      step();
    end
    bus.issue_valid = 1'b0;
    bus.q1_tag = 3'd2; bus.q2_tag = 3'd1;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd2; bus.cdb_value = 32'd7;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    check("t6_q1_rdy_same", 32'(bus.q1_ready), 1);
    check("t6_q1_val_same", bus.q1_value, 7);
`else
    check("t6_q1_rdy_same", 32'(bus.q1_ready), 0);
    check("t6_q1_val_same", bus.q1_value, 0);
`endif
    step();
    bus.cdb_valid = 1'b0;
    #1;
    check("t6_q1_rdy_next", 32'(bus.q1_ready), 1);
    check("t6_q1_val_next", bus.q1_value, 7);
    check("t6_q2_rdy", 32'(bus.q2_ready), 0);
    check("t6_q2_val", bus.q2_value, 0);
    check("t6_no_commit", 32'(bus.commit_valid), 0);

    // pause over a pending retire
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd0; bus.cdb_value = 32'haa;
    step();
    bus.cdb_valid = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_pause_cv", 32'(bus.commit_valid), 0);
      check("t7_pause_count", 32'(bus.count), 3);
    end
    rdy_in = 1'b1;
    step();
    check("t7_cv", 32'(bus.commit_valid), 1);
    check("t7_tag", 32'(bus.commit_tag), 0);
    check("t7_val", bus.commit_value, 32'haa);
    check("t7_count", 32'(bus.count), 2);
    rdy_in = 1'b0;
    #1 check("t7_masked", 32'(bus.commit_valid), 0);
    step();
    check("t7_masked_hold", 32'(bus.commit_valid), 0);
    rdy_in = 1'b1;
    #1 check("t7_represent", 32'(bus.commit_valid), 1);
    check("t7_represent_we", 32'(bus.commit_we), 1);
    step();
    check("t7_after_cv", 32'(bus.commit_valid), 0);
    check("t7_after_count", 32'(bus.count), 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
